// File: rtl/rally_sequencer.sv
// rally_sequencer: match-flow controller for the game engine.
// Runs the match through idle, serve wait, rally, point pause and match over.
// It issues one-cycle start/serve strobes and a freeze level, can serve
// automatically after a timeout, and tracks rally-length statistics.
module rally_sequencer #(
  parameter int unsigned TICK_DIV         = 500000,
  parameter int unsigned PAUSE_TICKS      = 100,
  parameter int unsigned AUTO_SERVE_TICKS = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       serve_btn,
  input  logic       auto_serve,
  input  logic       hit,
  input  logic       goal,
  input  logic       p1_win,
  input  logic       p2_win,
  output logic [2:0] state,
  output logic       start_pulse,
  output logic       serve_pulse,
  output logic       freeze,
  output logic [7:0] rally_hits,
  output logic [7:0] best_rally
);

  localparam int unsigned DivW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    StIdle       = 3'd0,
    StServeWait  = 3'd1,
    StRally      = 3'd2,
    StPointPause = 3'd3,
    StMatchOver  = 3'd4
  } state_e;

  state_e          st;
  logic            start_q;
  logic            serve_q;
  logic [DivW-1:0] div;
  logic [7:0]      ticks;

  logic            start_edge;
  logic            serve_edge;
  logic            tick;
  logic            pause_done;
  logic            auto_fire;
  logic [7:0]      hits_next;
  logic [7:0]      best_next;

  assign state = st;

  // Edge detection, tick decode and the rally statistics that feed the FSM.
  always_comb begin
    start_edge = start_btn & ~start_q;
    serve_edge = serve_btn & ~serve_q;
    tick       = (div == DivW'(TICK_DIV - 1));
    pause_done = tick && (ticks == 8'(PAUSE_TICKS - 1));
    auto_fire  = auto_serve && tick && (ticks == 8'(AUTO_SERVE_TICKS - 1));
    hits_next  = rally_hits;
    if (hit && (rally_hits != 8'hff)) begin
      hits_next = rally_hits + 8'd1;
    end
    // Includes a hit arriving in the same cycle as the goal.
    best_next = (hits_next > best_rally) ? hits_next : best_rally;
  end

  // Match FSM with registered strobes, freeze, timer and statistics.
  // Later assignments in a branch override the timer update, so every
  // transition clears div/ticks on entry to the new state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st          <= StIdle;
      start_q     <= 1'b1;
      serve_q     <= 1'b1;
      div         <= '0;
      ticks       <= '0;
      start_pulse <= 1'b0;
      serve_pulse <= 1'b0;
      freeze      <= 1'b1;
      rally_hits  <= '0;
      best_rally  <= '0;
    end else begin
      start_q     <= start_btn;
      serve_q     <= serve_btn;
      start_pulse <= 1'b0;
      serve_pulse <= 1'b0;
      case (st)
        StIdle, StMatchOver: begin
          if (start_edge) begin
            start_pulse <= 1'b1;
            st          <= StServeWait;
            freeze      <= 1'b0;
            div         <= '0;
            ticks       <= '0;
          end
        end
        StServeWait: begin
          // Timer only runs while auto-serve is enabled; dropping it restarts.
          if (!auto_serve) begin
            div   <= '0;
            ticks <= '0;
          end else if (tick) begin
            div   <= '0;
            ticks <= ticks + 8'd1;
          end else begin
            div <= div + 1'b1;
          end
          if (serve_edge || auto_fire) begin
            serve_pulse <= 1'b1;
            rally_hits  <= '0;
            st          <= StRally;
            freeze      <= 1'b0;
            div         <= '0;
            ticks       <= '0;
          end
        end
        StRally: begin
          rally_hits <= hits_next;
          if (goal) begin
            best_rally <= best_next;
            st         <= StPointPause;
            freeze     <= 1'b1;
            div        <= '0;
            ticks      <= '0;
          end
        end
        StPointPause: begin
          if (tick) begin
            div   <= '0;
            ticks <= ticks + 8'd1;
          end else begin
            div <= div + 1'b1;
          end
          if (pause_done) begin
            div   <= '0;
            ticks <= '0;
            if (p1_win || p2_win) begin
              st     <= StMatchOver;
              freeze <= 1'b1;
            end else begin
              st     <= StServeWait;
              freeze <= 1'b0;
            end
          end
        end
        default: begin
          st     <= StIdle;
          freeze <= 1'b1;
          div    <= '0;
          ticks  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rally_sequencer.sv
// Testbench for rally_sequencer: directed match scenarios plus a random soak,
// checked every cycle by a scoreboard fed from a cycle-count reference model.
module tb_rally_sequencer;

  localparam int TD = 4;
  localparam int PT = 3;
  localparam int AT = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_btn = 1'b0;
  logic       serve_btn = 1'b0;
  logic       auto_serve = 1'b0;
  logic       hit = 1'b0;
  logic       goal = 1'b0;
  logic       p1_win = 1'b0;
  logic       p2_win = 1'b0;
  logic [2:0] state;
  logic       start_pulse;
  logic       serve_pulse;
  logic       freeze;
  logic [7:0] rally_hits;
  logic [7:0] best_rally;

  rally_sequencer #(
    .TICK_DIV         (TD),
    .PAUSE_TICKS      (PT),
    .AUTO_SERVE_TICKS (AT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_btn   (start_btn),
    .serve_btn   (serve_btn),
    .auto_serve  (auto_serve),
    .hit         (hit),
    .goal        (goal),
    .p1_win      (p1_win),
    .p2_win      (p2_win),
    .state       (state),
    .start_pulse (start_pulse),
    .serve_pulse (serve_pulse),
    .freeze      (freeze),
    .rally_hits  (rally_hits),
    .best_rally  (best_rally)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       sp;
    logic       vp;
    logic       fr;
    logic [7:0] hits;
    logic [7:0] best;
  } obs_t;

  obs_t exp_q[$];
  int   n_tests = 0;
  int   n_fail = 0;

  // Reference model: state plus cycles spent in the current timed wait.
  int m_st, m_hits, m_best, m_cnt;
  bit m_ps, m_pv, m_sp, m_vp;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_hits = 0; m_best = 0; m_cnt = 0;
    m_ps = 1; m_pv = 1; m_sp = 0; m_vp = 0;
  endtask

  task automatic model_update();
    bit se, ve;
    int nst;
    se = start_btn && !m_ps;
    ve = serve_btn && !m_pv;
    m_sp = 0;
    m_vp = 0;
    nst = m_st;
    case (m_st)
      0, 4: if (se) begin m_sp = 1; nst = 1; end
      1: begin
        if (ve || (auto_serve && m_cnt == AT * TD - 1)) begin
          m_vp = 1; m_hits = 0; nst = 2;
        end else begin
          m_cnt = auto_serve ? m_cnt + 1 : 0;
        end
      end
      2: begin
        if (hit) m_hits = (m_hits < 255) ? m_hits + 1 : 255;
        if (goal) begin
          nst = 3;
          if (m_hits > m_best) m_best = m_hits;
        end
      end
      3: begin
        if (m_cnt == PT * TD - 1) nst = (p1_win || p2_win) ? 4 : 1;
        else m_cnt++;
      end
      default: nst = 0;
    endcase
    if (nst != m_st) m_cnt = 0;
    m_st = nst;
    m_ps = start_btn;
    m_pv = serve_btn;
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.st   = 3'(m_st);
    o.sp   = m_sp;
    o.vp   = m_vp;
    o.fr   = (m_st == 0) || (m_st == 3) || (m_st == 4);
    o.hits = 8'(m_hits);
    o.best = 8'(m_best);
    return o;
  endfunction

  // One clock: caller sets inputs at the negedge; model predicts this edge.
  task automatic step();
    @(posedge clk);
    model_update();
    exp_q.push_back(model_obs());
    @(negedge clk);
  endtask

  task automatic pulse_hit(input bit with_goal);
    hit = 1; goal = with_goal; step(); hit = 0; goal = 0;
  endtask

  task automatic press_serve();
    serve_btn = 1; step(); serve_btn = 0; step();
  endtask

  // Monitor: compare DUT outputs against the queued prediction.
  obs_t mon_e, mon_a;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = {state, start_pulse, serve_pulse, freeze, rally_hits, best_rally};
      n_tests++;
      if (mon_a !== mon_e) begin
        n_fail++;
        $display("FAIL scoreboard: got st=%0d sp=%b vp=%b fr=%b hits=%0d best=%0d expected st=%0d sp=%b vp=%b fr=%b hits=%0d best=%0d at %0t",
                 mon_a.st, mon_a.sp, mon_a.vp, mon_a.fr, mon_a.hits, mon_a.best,
                 mon_e.st, mon_e.sp, mon_e.vp, mon_e.fr, mon_e.hits, mon_e.best, $time);
      end
    end
  end

  initial begin
    int n;
    model_reset();
    // Reset with start held: no edge after release.
    start_btn = 1;
    @(negedge clk);
    check("reset_state", int'(state), 0);
    check("reset_freeze", int'(freeze), 1);
    check("reset_best", int'(best_rally), 0);
    rst = 0;
    repeat (3) step();
    check("held_start_idle", int'(state), 0);
    start_btn = 0; step();
    start_btn = 1; step();
    check("start_pulse", int'(start_pulse), 1);
    check("start_state", int'(state), 1);
    check("start_freeze", int'(freeze), 0);
    start_btn = 0; step();
    check("start_pulse_one_cycle", int'(start_pulse), 0);

    // Manual serve and rally ending with simultaneous hit+goal.
    serve_btn = 1; step();
    check("serve_pulse", int'(serve_pulse), 1);
    check("serve_state", int'(state), 2);
    serve_btn = 0; step();
    check("serve_pulse_one_cycle", int'(serve_pulse), 0);
    for (int i = 0; i < 3; i++) begin
      pulse_hit(0);
      repeat ($urandom_range(0, 2)) step();
    end
    pulse_hit(1);
    check("rally_hits_4", int'(rally_hits), 4);
    check("pause_state", int'(state), 3);
    check("best_4", int'(best_rally), 4);
    check("pause_freeze", int'(freeze), 1);

    // Pause length with no winner.
    n = 0;
    while (state != 3'd1 && n < 50) begin step(); n++; end
    check("pause_cycles", n, PT * TD);

    // Next point ends the match.
    press_serve();
    p1_win = 1;
    pulse_hit(1);
    n = 0;
    while (state == 3'd3 && n < 50) begin step(); n++; end
    check("match_over_cycles", n, PT * TD);
    check("match_over_state", int'(state), 4);
    start_btn = 1; step();
    check("restart_pulse", int'(start_pulse), 1);
    check("restart_state", int'(state), 1);
    check("best_retained", int'(best_rally), 4);
    start_btn = 0; p1_win = 0; step();

    // Auto-serve with auto_serve high across entry into serve wait.
    press_serve();
    pulse_hit(1);
    auto_serve = 1;
    n = 0;
    while (state != 3'd1 && n < 50) begin step(); n++; end
    n = 0;
    while (!serve_pulse && n < 60) begin step(); n++; end
    check("auto_serve_cycles", n, AT * TD);

    // Drop auto_serve mid-count: count restarts when it returns.
    pulse_hit(1);
    n = 0;
    while (state != 3'd1 && n < 50) begin step(); n++; end
    repeat (10) step();
    auto_serve = 0;
    repeat (3) step();
    auto_serve = 1;
    n = 0;
    while (!serve_pulse && n < 60) begin step(); n++; end
    check("auto_restart_cycles", n, AT * TD);
    auto_serve = 0;

    // Saturation.
    hit = 1;
    repeat (300) step();
    hit = 0;
    check("hits_saturate", int'(rally_hits), 255);
    pulse_hit(1);
    check("best_saturate", int'(best_rally), 255);
    n = 0;
    while (state != 3'd1 && n < 50) begin step(); n++; end

    // hit/goal ignored in serve wait.
    for (int i = 0; i < 4; i++) pulse_hit(i[0]);
    check("ignore_sw_state", int'(state), 1);
    check("ignore_sw_hits", int'(rally_hits), 255);

    // Async reset in the middle of a pause.
    press_serve();
    pulse_hit(1);
    repeat (3) step();
    @(posedge clk);
    model_update();
    exp_q.push_back(model_obs());
    #2;
    rst = 1;
    exp_q.delete();
    #1;
    check("async_state", int'(state), 0);
    check("async_freeze", int'(freeze), 1);
    check("async_hits", int'(rally_hits), 0);
    check("async_best", int'(best_rally), 0);
    check("async_strobes", int'({start_pulse, serve_pulse}), 0);
    #4;
    rst = 0;
    model_reset();
    step();

    // hit/goal/serve ignored in idle.
    for (int i = 0; i < 4; i++) pulse_hit(i[0]);
    press_serve();
    check("ignore_idle_state", int'(state), 0);
    check("ignore_idle_hits", int'(rally_hits), 0);

    // Random soak.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) start_btn = ~start_btn;
      if ($urandom_range(0, 7) == 0) serve_btn = ~serve_btn;
      if ($urandom_range(0, 63) == 0) auto_serve = ~auto_serve;
      if ($urandom_range(0, 31) == 0) p1_win = ~p1_win;
      if ($urandom_range(0, 47) == 0) p2_win = ~p2_win;
      hit  = ($urandom_range(0, 2) == 0);
      goal = ($urandom_range(0, 19) == 0);
      step();
    end
    hit = 0; goal = 0;
    step();
    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rally_sequencer.md
# rally_sequencer

Match-flow controller that sequences `game_controller` through start, serve, rally, inter-point pause and match-over. It sits between the debounced start/serve buttons and the game engine. It issues one-cycle `start_pulse`/`serve_pulse` strobes and a `freeze` level that holds the paddles and ball between points. It also provides an optional timed auto-serve and rally-length statistics for the video overlay.

## Interface
- `TICK_DIV`, 500000: clk cycles per timing tick (10 ms at 50 MHz).
- `PAUSE_TICKS`, 100: ticks spent in POINT_PAUSE, range 1..255.
- `AUTO_SERVE_TICKS`, 200: ticks in SERVE_WAIT before auto-serve, range 1..255.
- `clk` in 1: system clock; all state on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start_btn` in 1: debounced start level, active high.
- `serve_btn` in 1: debounced serve level, active high.
- `auto_serve` in 1: enables timed serve in SERVE_WAIT.
- `hit` in 1: one-cycle paddle-hit strobe from the game engine.
- `goal` in 1: one-cycle point-scored strobe.
- `p1_win`, `p2_win` in 1: match-won levels from the game engine.
- `state` out 3: 0 IDLE, 1 SERVE_WAIT, 2 RALLY, 3 POINT_PAUSE, 4 MATCH_OVER.
- `start_pulse` out 1: one-cycle match start/restart strobe.
- `serve_pulse` out 1: one-cycle serve strobe.
- `freeze` out 1: high in IDLE, POINT_PAUSE and MATCH_OVER.
- `rally_hits` out 8: hits in the current or last rally, saturating.
- `best_rally` out 8: maximum `rally_hits` since reset.

## Operation
- Edge detect: registered previous values `start_q` and `serve_q`, both reset to 1. A rising edge is `btn & ~btn_q`. A button held through reset gives no edge until it is released and pressed again.
- Timer: prescaler `div` (0..TICK_DIV-1) plus 8-bit `ticks`. Both clear on every state entry. `tick` = (`div`==TICK_DIV-1). `ticks` increments on `tick`.
- IDLE:
  - start edge → `start_pulse`, go to SERVE_WAIT.
  - A serve edge in the same cycle is ignored.
- SERVE_WAIT:
  - serve edge → `serve_pulse`, clear `rally_hits`, go to RALLY.
  - Else if `auto_serve` and `tick` and `ticks`==AUTO_SERVE_TICKS-1 → same action.
  - While `auto_serve`=0, `div` and `ticks` are held at 0.
- RALLY:
  - `hit` increments `rally_hits`, saturating at 255.
  - `goal` → go to POINT_PAUSE.
  - `hit` and `goal` in the same cycle: count the hit and transition.
- POINT_PAUSE:
  - On `tick` with `ticks`==PAUSE_TICKS-1: if `p1_win|p2_win`, go to MATCH_OVER; else go to SERVE_WAIT.
  - On entry, `best_rally` <= max(`best_rally`, `rally_hits`), using the final `rally_hits` including a simultaneous hit.
- MATCH_OVER: start edge → `start_pulse`, go to SERVE_WAIT. Statistics are retained.
- Ignored inputs:
  - `goal` and `hit` outside RALLY.
  - serve edges outside SERVE_WAIT.
  - start edges outside IDLE/MATCH_OVER.
- Illegal state codes 5–7 recover to IDLE on the next clock.

## Timing
- All outputs are registered.
- Reset values: `state`=0, `start_pulse`=0, `serve_pulse`=0, `freeze`=1, `rally_hits`=0, `best_rally`=0, all counters 0.
- Strobe timing: the input edge is sampled at clock edge N. The strobe is high for cycle N..N+1 only, and `state` updates at the same edge N.
- `freeze` updates on the same edge as `state`.
- POINT_PAUSE lasts exactly PAUSE_TICKS×TICK_DIV cycles.
- Auto-serve fires exactly AUTO_SERVE_TICKS×TICK_DIV cycles after entry into SERVE_WAIT, with `auto_serve` held high throughout.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock. The first cycle after release behaves as IDLE.

## Test plan
Parameters for all scenarios: TICK_DIV=4, PAUSE_TICKS=3, AUTO_SERVE_TICKS=5.
- **Reset / held button:** hold `start_btn`=1 through reset release → `state` stays 0, no `start_pulse`. Release, then press → `start_pulse` high exactly 1 cycle, `state`=1, `freeze`=0.
- **Manual serve and rally:** serve edge → `serve_pulse` 1 cycle, `state`=2. Drive 3 `hit` pulses, then `hit`+`goal` in the same cycle → `rally_hits`=4, `state`=3, `best_rally`=4, `freeze`=1.
- **Pause length:** after entering POINT_PAUSE with `p*_win`=0 → `state` returns to 1 exactly 12 cycles later. Repeat with `p1_win`=1 → `state`=4. Then a start edge → `start_pulse`, `state`=1, `best_rally` retained.
- **Auto-serve:** `auto_serve`=1 on entering SERVE_WAIT → `serve_pulse` exactly 20 cycles after entry. Drop `auto_serve` at cycle 10 and raise it again → the count restarts from 0.
- **Saturation and ignored inputs:** 300 `hit` pulses in RALLY → `rally_hits`=255. `goal`/`hit` pulses in IDLE and SERVE_WAIT → no state or counter change.
- **Async reset mid-pause:** assert `rst` for half a cycle during POINT_PAUSE → `state`=0, `freeze`=1, counters 0, all without waiting for a clock edge.
